snax_alu_out_serializer: RTL and testbench
==========================================

SNAX_ALU_OUT_SERIALIZER -- requirements
Module: snax_alu_out_serializer

Interface
REQ-001: NumPE SHALL be a parameter, default 4, giving the number of ALU PEs feeding the block.
REQ-002: DataWidth SHALL be a parameter, default 64, giving the per-PE operand width; input word width InWidth = NumPE*DataWidth*2.
REQ-003: OutWidth SHALL be a parameter, default 128, giving the streamer beat width; Ratio = InWidth/OutWidth.
REQ-004: clk_i  input  1  single clock; all state on rising edge.
REQ-005: rst_ni  input  1  reset, asynchronous, active-low.
REQ-006: acc2ser_data_i  input  InWidth  result word from the ALU wrapper.
REQ-007: acc2ser_valid_i  input  1  result word valid.
REQ-008: acc2ser_ready_o  output  1  block accepts a result word.
REQ-009: ser2stream_data_o  output  OutWidth  current output beat.
REQ-010: ser2stream_valid_o  output  1  output beat valid.
REQ-011: ser2stream_ready_i  input  1  streamer accepts the beat.
REQ-012: clear_i  input  1  synchronous abort, from the CSR side.
REQ-013: words_done_o  output  32  count of fully sent words, present only with the Configuration macro.

Function
REQ-014: Elaboration SHALL fail if InWidth is not an exact multiple of OutWidth or Ratio < 1.
REQ-015: The FSM SHALL have exactly two states: IDLE (buffer empty) and SEND (buffer holds a word).
REQ-016: In IDLE, acc2ser_ready_o = 1 and ser2stream_valid_o = 0.
REQ-017: An input handshake (valid & ready) SHALL latch acc2ser_data_i into a buffer, set beat index to 0, and enter SEND on the next cycle.
REQ-018: In SEND, ser2stream_valid_o = 1 and ser2stream_data_o = buffer[beat*OutWidth +: OutWidth], LSB slice first.
REQ-019: Output data SHALL remain stable while valid is high and ser2stream_ready_i is low.
REQ-020: An output handshake on a beat < Ratio-1 SHALL increment the beat index only.
REQ-021: In SEND, acc2ser_ready_o = (beat == Ratio-1) & ser2stream_ready_i; this combinational ready path is intentional and enables back-to-back words.
REQ-022: An output handshake on the last beat with a simultaneous input handshake SHALL reload the buffer, reset beat to 0, and stay in SEND with no bubble cycle.
REQ-023: An output handshake on the last beat without an input handshake SHALL return to IDLE.
REQ-024: With Ratio = 1, each word SHALL take exactly one output beat and throughput SHALL be one word per cycle under continuous ready.
REQ-025: Latency from the input handshake to the first beat valid SHALL be exactly 1 cycle.
REQ-026: clear_i high SHALL force IDLE and beat 0 on the next edge, dropping the buffered word; clear_i has priority over both handshakes.
REQ-027: During a cycle with clear_i high, acc2ser_ready_o SHALL be 0 and no input handshake SHALL occur.

Reset
REQ-028: On rst_ni low, state SHALL go to IDLE, beat to 0, buffer to 0, and words_done_o to 0 immediately, with ser2stream_valid_o = 0 and acc2ser_ready_o = 1 while rst_ni is low.
REQ-029: Reset asserted mid-word SHALL discard the partial word; after release the block SHALL accept a new word with no residual beats.

Configuration
REQ-030: Macro SNAX_ALU_SER_PERF_EN SHALL control the performance counter.
REQ-031: When defined, words_done_o SHALL increment by 1 on each last-beat output handshake, wrap from 2^32-1 to 0, and hold on clear_i.
REQ-032: When undefined, the words_done_o port and its counter SHALL be absent; all other behaviour is unchanged.

Verification
REQ-033: Basic serialization (defaults, Ratio = 4): input word with 128-bit slices 0xA..,0xB..,0xC..,0xD.. (LSB first), ready_i = 1 -> beats A,B,C,D on 4 consecutive cycles starting 1 cycle after accept.
REQ-034: Backpressure: ready_i low for 3 cycles on beat 1 -> beat 1 data held constant, then C and D follow; no beat lost or duplicated.
REQ-035: Back-to-back: two words with valid_i held high and ready_i = 1 -> 8 contiguous valid beats with no bubble; ready_o pulses only on the last-beat cycle.
REQ-036: Clear mid-word: clear_i during beat 2 -> valid_o = 0 the next cycle, ready_o = 1, and the next word starts at beat 0.
REQ-037: Async reset: rst_ni dropped between clock edges during SEND -> valid_o = 0 immediately; with PERF_EN, words_done_o = 0.
REQ-038: Counter (PERF_EN): preload near wrap, send 3 words from 0xFFFFFFFE -> counter reads 0xFFFFFFFF, 0x0, 0x1.

Source files
------------

// File: rtl/snax_alu_out_serializer.sv
// Splits one wide ALU result word into Ratio beats of OutWidth bits, LSB slice first.
// Optional feature macro: SNAX_ALU_SER_PERF_EN adds the words_done_o word counter.
module snax_alu_out_serializer #(
    parameter int unsigned NumPE     = 4,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned OutWidth  = 128
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NumPE*DataWidth*2-1:0] acc2ser_data_i,
    input  logic                         acc2ser_valid_i,
    output logic                         acc2ser_ready_o,
    output logic [OutWidth-1:0]          ser2stream_data_o,
    output logic                         ser2stream_valid_o,
    input  logic                         ser2stream_ready_i,
    input  logic                         clear_i
`ifdef SNAX_ALU_SER_PERF_EN
    ,
    output logic [31:0]                  words_done_o
`endif
);

    localparam int unsigned InWidth = NumPE * DataWidth * 2;
    localparam int unsigned Ratio   = InWidth / OutWidth;
    localparam int unsigned BeatW   = (Ratio > 1) ? $clog2(Ratio) : 1;

    if ((InWidth % OutWidth) != 0 || Ratio < 1) begin : g_bad_cfg
        $error("snax_alu_out_serializer: InWidth must be a non-zero multiple of OutWidth");
    end

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [BeatW-1:0]   beat_q,  beat_d;
    logic [InWidth-1:0] word_q,  word_d;

    logic last_beat;
    logic in_hs;
    logic out_hs;

    assign last_beat = (beat_q == BeatW'(Ratio - 1));

    // Ready is combinational on purpose: the last beat leaving and the next word
    // arriving share one cycle, so back-to-back words run without a bubble.
    assign acc2ser_ready_o    = ~clear_i & ((state_q == IDLE) | (last_beat & ser2stream_ready_i));
    assign ser2stream_valid_o = (state_q == SEND);

    assign in_hs  = acc2ser_valid_i & acc2ser_ready_o;
    assign out_hs = ser2stream_valid_o & ser2stream_ready_i & ~clear_i;

    if (Ratio == 1) begin : g_single_beat
        assign ser2stream_data_o = word_q;
    end else begin : g_multi_beat
        assign ser2stream_data_o = word_q[beat_q*OutWidth +: OutWidth];
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so that no
        // path through the branches below can infer a latch.
        state_d = state_q;
        beat_d  = beat_q;
        word_d  = word_q;
        if (clear_i) begin
            state_d = IDLE;
            beat_d  = '0;
        end else begin
            if (out_hs) begin
                if (last_beat) begin
                    state_d = IDLE;
                end else begin
                    beat_d = beat_q + BeatW'(1);
                end
            end
            // An accepted word overrides the last-beat return to IDLE.
            if (in_hs) begin
                word_d  = acc2ser_data_i;
                beat_d  = '0;
                state_d = SEND;
            end
        end
    end

    // NOTE: the word buffer is a plain register, so it is reset together with the
    // control state; a reset therefore never exposes a stale word on the output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            beat_q  <= '0;
            word_q  <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q <= state_d;
            beat_q  <= beat_d;
            word_q  <= word_d;
        end
    end

`ifdef SNAX_ALU_SER_PERF_EN
    logic [31:0] words_done_q;

    // Counts completed words; clear_i blocks out_hs, so the count holds on clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            words_done_q <= '0;
        end else if (out_hs && last_beat) begin
            words_done_q <= words_done_q + 32'd1;
        end
    end

    assign words_done_o = words_done_q;
`endif

endmodule

// File: tb/tb_snax_alu_out_serializer.sv
// Self-checking bench for snax_alu_out_serializer: directed scenarios plus a
// randomized run scored against a queue-of-beats reference model.
module tb_snax_alu_out_serializer;

    localparam int InW  = 512;
    localparam int OutW = 128;
    localparam int Rat  = InW / OutW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [InW-1:0]  in_data;
    logic            in_valid;
    logic            in_ready;
    logic [OutW-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic            clear;

    logic [InW-1:0]  r1_in_data;
    logic            r1_in_valid;
    logic            r1_in_ready;
    logic [InW-1:0]  r1_out_data;
    logic            r1_out_valid;
    logic            r1_out_ready;
    logic            r1_clear;

`ifdef SNAX_ALU_SER_PERF_EN
    logic [31:0] words_done;
    logic [31:0] r1_words_done;
`endif

    int checks;
    int errors;

    always #5 clk = ~clk;

    snax_alu_out_serializer #(.NumPE(4), .DataWidth(64), .OutWidth(128)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .acc2ser_data_i     (in_data),
        .acc2ser_valid_i    (in_valid),
        .acc2ser_ready_o    (in_ready),
        .ser2stream_data_o  (out_data),
        .ser2stream_valid_o (out_valid),
        .ser2stream_ready_i (out_ready),
        .clear_i            (clear)
`ifdef SNAX_ALU_SER_PERF_EN
        ,
        .words_done_o       (words_done)
`endif
    );

    snax_alu_out_serializer #(.NumPE(4), .DataWidth(64), .OutWidth(512)) dut_r1 (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .acc2ser_data_i     (r1_in_data),
        .acc2ser_valid_i    (r1_in_valid),
        .acc2ser_ready_o    (r1_in_ready),
        .ser2stream_data_o  (r1_out_data),
        .ser2stream_valid_o (r1_out_valid),
        .ser2stream_ready_i (r1_out_ready),
        .clear_i            (r1_clear)
`ifdef SNAX_ALU_SER_PERF_EN
        ,
        .words_done_o       (r1_words_done)
`endif
    );

    function automatic logic [InW-1:0] rand_word();
        logic [InW-1:0] w;
        for (int i = 0; i < InW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [OutW-1:0] slice_of(input logic [InW-1:0] w, input int k);
        return w[k*OutW +: OutW];
    endfunction

    task automatic test_reset();
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", in_ready); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", out_data); end
        checks++; if (r1_in_ready !== 1'b1 || r1_out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_r1 ready %b valid %b exp 1 0", r1_in_ready, r1_out_valid);
        end
`ifdef SNAX_ALU_SER_PERF_EN
        checks++; if (words_done !== 32'd0) begin errors++; $display("FAIL reset_count got %h exp 0", words_done); end
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release valid %b ready %b exp 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_basic();
        logic [OutW-1:0] sl [Rat];
        sl[0] = 128'hA000_0000_1111_2222_3333_4444_5555_00A1;
        sl[1] = 128'hB000_0000_6666_7777_8888_9999_AAAA_00B2;
        sl[2] = 128'hC000_0000_BBBB_CCCC_DDDD_EEEE_FFFF_00C3;
        sl[3] = 128'hD000_0000_0123_4567_89AB_CDEF_0F0F_00D4;
        @(negedge clk);
        in_data = {sl[3], sl[2], sl[1], sl[0]}; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_idle ready %b valid %b exp 1 0", in_ready, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0; in_data = '0;
        for (int k = 0; k < Rat; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            checks++; if (out_valid !== 1'b1 || out_data !== sl[k]) begin
                errors++; $display("FAIL basic_beat%0d valid %b data %h exp 1 %h", k, out_valid, out_data, sl[k]);
            end
            checks++; if (in_ready !== (k == Rat - 1)) begin
                errors++; $display("FAIL basic_ready%0d got %b exp %b", k, in_ready, (k == Rat - 1));
            end
        end
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL basic_end valid %b ready %b exp 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [InW-1:0] w;
        int cur;
        bit rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        w = rand_word();
        cur = 0;
        @(negedge clk);
        in_data = w; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            out_ready = rdy[i];
            #1;
            checks++; if (out_valid !== 1'b1 || out_data !== slice_of(w, cur)) begin
                errors++; $display("FAIL bp_cycle%0d valid %b data %h exp 1 %h", i, out_valid, out_data, slice_of(w, cur));
            end
            if (rdy[i]) cur++;
        end
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b0 || cur != Rat) begin
            errors++; $display("FAIL bp_end valid %b beats %0d exp 0 %0d", out_valid, cur, Rat);
        end
    endtask

    task automatic test_back_to_back();
        logic [InW-1:0] w [2];
        w[0] = rand_word();
        w[1] = rand_word();
        @(negedge clk);
        in_data = w[0]; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_first_ready got %b exp 1", in_ready); end
        for (int j = 0; j < 2 * Rat; j++) begin
            @(negedge clk);
            in_data  = w[1];
            in_valid = (j < Rat);
            #1;
            checks++; if (out_valid !== 1'b1 || out_data !== slice_of(w[j / Rat], j % Rat)) begin
                errors++; $display("FAIL b2b_beat%0d valid %b data %h exp 1 %h", j, out_valid, out_data, slice_of(w[j / Rat], j % Rat));
            end
            checks++; if (in_ready !== ((j % Rat) == Rat - 1)) begin
                errors++; $display("FAIL b2b_ready%0d got %b exp %b", j, in_ready, ((j % Rat) == Rat - 1));
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end valid got %b exp 0", out_valid); end
    endtask

    task automatic test_clear();
        logic [InW-1:0] w1, w2;
        w1 = rand_word();
        w2 = rand_word();
        @(negedge clk);
        in_data = w1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b1; in_data = w2;
        #1;
        checks++; if (out_data !== slice_of(w1, 2)) begin
            errors++; $display("FAIL clr_beat2 data %h exp %h", out_data, slice_of(w1, 2));
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clr_ready got %b exp 0", in_ready); end
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL clr_after valid %b ready %b exp 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < Rat; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            checks++; if (out_valid !== 1'b1 || out_data !== slice_of(w2, k)) begin
                errors++; $display("FAIL clr_next%0d valid %b data %h exp 1 %h", k, out_valid, out_data, slice_of(w2, k));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        logic [InW-1:0] w1, w2;
        w1 = rand_word();
        w2 = rand_word();
        @(negedge clk);
        in_data = w1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (out_data !== slice_of(w1, 1)) begin
            errors++; $display("FAIL arst_pre data %h exp %h", out_data, slice_of(w1, 1));
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
            errors++; $display("FAIL arst_now valid %b ready %b data %h exp 0 1 0", out_valid, in_ready, out_data);
        end
`ifdef SNAX_ALU_SER_PERF_EN
        checks++; if (words_done !== 32'd0) begin errors++; $display("FAIL arst_count got %h exp 0", words_done); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        in_data = w2; in_valid = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL arst_release valid %b ready %b exp 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < Rat; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            checks++; if (out_valid !== 1'b1 || out_data !== slice_of(w2, k)) begin
                errors++; $display("FAIL arst_beat%0d valid %b data %h exp 1 %h", k, out_valid, out_data, slice_of(w2, k));
            end
        end
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_residual valid got %b exp 0", out_valid); end
    endtask

    task automatic test_ratio1();
        logic [InW-1:0] w [7];
        for (int i = 0; i < 7; i++) w[i] = rand_word();
        @(negedge clk);
        r1_in_data = w[0]; r1_in_valid = 1'b1; r1_out_ready = 1'b1;
        #1;
        checks++; if (r1_in_ready !== 1'b1 || r1_out_valid !== 1'b0) begin
            errors++; $display("FAIL r1_idle ready %b valid %b exp 1 0", r1_in_ready, r1_out_valid);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            r1_in_data = w[i + 1];
            #1;
            checks++; if (r1_out_valid !== 1'b1 || r1_out_data !== w[i] || r1_in_ready !== 1'b1) begin
                errors++; $display("FAIL r1_word%0d valid %b ready %b data %h exp 1 1 %h", i, r1_out_valid, r1_in_ready, r1_out_data, w[i]);
            end
        end
        @(negedge clk);
        r1_in_valid = 1'b0;
        #1;
        checks++; if (r1_out_valid !== 1'b1 || r1_out_data !== w[6]) begin
            errors++; $display("FAIL r1_last valid %b data %h exp 1 %h", r1_out_valid, r1_out_data, w[6]);
        end
        @(negedge clk); #1;
        checks++; if (r1_out_valid !== 1'b0) begin errors++; $display("FAIL r1_end valid got %b exp 0", r1_out_valid); end
    endtask

    task automatic test_random();
        logic [OutW-1:0] q [$];
        logic            exp_valid, exp_ready;
        int              words_sent = 0;
`ifdef SNAX_ALU_SER_PERF_EN
        logic [31:0]     count_start = words_done;
`endif
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            clear     = ($urandom_range(0, 24) == 0);
            in_data   = rand_word();
            #1;
            exp_valid = (q.size() != 0);
            exp_ready = !clear && (q.size() == 0 || (q.size() == 1 && out_ready));
            checks++; if (out_valid !== exp_valid) begin
                errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", cyc, out_valid, exp_valid);
            end
            checks++; if (in_ready !== exp_ready) begin
                errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", cyc, in_ready, exp_ready);
            end
            if (exp_valid) begin
                checks++; if (out_data !== q[0]) begin
                    errors++; $display("FAIL rnd_data cyc %0d got %h exp %h", cyc, out_data, q[0]);
                end
            end
            if (clear) begin
                q.delete();
            end else begin
                if (exp_valid && out_ready) begin
                    void'(q.pop_front());
                    if (q.size() == 0) words_sent++;
                end
                if (in_valid && exp_ready) begin
                    for (int k = 0; k < Rat; k++) q.push_back(slice_of(in_data, k));
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
`ifdef SNAX_ALU_SER_PERF_EN
        checks++; if (words_done - count_start !== 32'(words_sent)) begin
            errors++; $display("FAIL rnd_count got %0d exp %0d", words_done - count_start, words_sent);
        end
`endif
    endtask

`ifdef SNAX_ALU_SER_PERF_EN
    task automatic test_counter();
        logic [31:0] exp_cnt [3] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        @(negedge clk);
        force dut.words_done_q = 32'hFFFF_FFFE;
        #1;
        release dut.words_done_q;
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            in_data = rand_word(); in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            repeat (Rat) @(negedge clk);
            #1;
            checks++; if (words_done !== exp_cnt[n]) begin
                errors++; $display("FAIL cnt_word%0d got %h exp %h", n, words_done, exp_cnt[n]);
            end
        end
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        checks++; if (words_done !== 32'h0000_0001) begin
            errors++; $display("FAIL cnt_hold got %h exp 00000001", words_done);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
        r1_in_data = '0; r1_in_valid = 1'b0; r1_out_ready = 1'b0; r1_clear = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_clear();
        test_async_reset();
        test_ratio1();
        test_random();
`ifdef SNAX_ALU_SER_PERF_EN
        test_counter();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
